partial_sort_engine: RTL

Iterative partial sorter for frames of N signed 16-bit samples. It loads a frame over a valid/ready stream and sorts it in place with odd-even transposition passes, using N/2 instances of the ascending compare-and-swap cell (min to lower index, max to upper). It then streams the K smallest samples out in ascending order. It sits between the sample source and the downstream top-K consumer.

---
 rtl/partial_sort_engine.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/partial_sort_engine.sv
// Iterative partial sorter: loads N signed samples, sorts them in place with N
// odd-even transposition passes, then streams out the K smallest in ascending order.

module compare_swap #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] lo,
  output logic signed [W-1:0] hi
);
  logic swap;

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

module partial_sort_engine #(
  parameter int N = 8,
  parameter int K = 4,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy
);
  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(K - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] load_cnt, pass_cnt, out_idx;
  logic signed [W-1:0] sort_buf     [N];
  logic signed [W-1:0] sort_buf_nxt [N];
  logic signed [W-1:0] cell_a  [N/2];
  logic signed [W-1:0] cell_b  [N/2];
  logic signed [W-1:0] cell_lo [N/2];
  logic signed [W-1:0] cell_hi [N/2];
  logic odd_pass, accept, emit, last_out;

  assign odd_pass = pass_cnt[0];
  assign accept   = in_valid && (state == S_LOAD);
  assign emit     = out_ready && (state == S_OUT);
  assign last_out = (out_idx == LAST_OUT);

  // Cells are rewired between pair phases; the top cell idles on odd passes.
  for (genvar i = 0; i < N/2; i++) begin : g_cell
    if (i < N/2 - 1) begin : g_mux
      assign cell_a[i] = odd_pass ? sort_buf[2*i+1] : sort_buf[2*i];
      assign cell_b[i] = odd_pass ? sort_buf[2*i+2] : sort_buf[2*i+1];
    end else begin : g_fixed
      assign cell_a[i] = sort_buf[2*i];
      assign cell_b[i] = sort_buf[2*i+1];
    end
    compare_swap #(.W(W)) u_cs (
      .a  (cell_a[i]),
      .b  (cell_b[i]),
      .lo (cell_lo[i]),
      .hi (cell_hi[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // NOTE: every output is given a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (accept && load_cnt == LAST_IDX) state_nxt = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (pass_cnt == LAST_IDX) state_nxt = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sort_buf[out_idx[IW-1:0]];
        out_last  = last_out;
        if (emit && last_out) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= '0;
      pass_cnt <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            load_cnt <= (load_cnt == LAST_IDX) ? '0 : load_cnt + ONE;
            pass_cnt <= '0;
          end
        end
        S_SORT: begin
          pass_cnt <= pass_cnt + ONE;
          if (pass_cnt == LAST_IDX) out_idx <= '0;
        end
        S_OUT: begin
          if (emit) out_idx <= out_idx + ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) sort_buf_nxt[i] = sort_buf[i];
    if (accept) begin
      sort_buf_nxt[load_cnt[IW-1:0]] = in_data;
    end else if (state == S_SORT) begin
      if (odd_pass) begin
        for (int i = 0; i < N/2 - 1; i++) begin
          sort_buf_nxt[2*i+1] = cell_lo[i];
          sort_buf_nxt[2*i+2] = cell_hi[i];
        end
      end else begin
        for (int i = 0; i < N/2; i++) begin
          sort_buf_nxt[2*i]   = cell_lo[i];
          sort_buf_nxt[2*i+1] = cell_hi[i];
        end
      end
    end
  end

  // NOTE: the sample store has no reset; a frame always overwrites every
  // entry before it is read, and leaving it out keeps it a plain register file.
  always_ff @(posedge clk) begin
    sort_buf <= sort_buf_nxt;
  end

endmodule
